// File: rtl/font_rom_arbiter_if.sv
// font_rom_arbiter_if: requester, ROM and response signals of the font ROM arbiter.
interface font_rom_arbiter_if #(parameter int N_REQ = 4, ADDR_W = 11, DATA_W = 8);
  logic [N_REQ-1:0] req, req_burst, gnt, rsp_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] rom_addr;
  logic rom_en, rsp_last;
  logic [DATA_W-1:0] rom_data, rsp_data;
  modport slave (
    input req, req_burst, req_addr, rom_data,
    output gnt, rom_addr, rom_en, rsp_valid, rsp_data, rsp_last
  );
  modport master (
    output req, req_burst, req_addr, rom_data,
    input gnt, rom_addr, rom_en, rsp_valid, rsp_data, rsp_last
  );
endinterface

// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: round-robin sharing of one synchronous font ROM, single-row reads or 16-row bursts.
module font_rom_arbiter #(parameter int N_REQ = 4, ADDR_W = 11, DATA_W = 8) (
  input logic Clk,
  input logic Reset_n,
  font_rom_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_nx;
  logic [IW-1:0] last_winner, owner, win, idx;
  logic [3:0] row;
  logic [ADDR_W-1:0] base;
  logic found, grant, rsp_last_q;
  logic [N_REQ-1:0] rsp_valid_q;
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IW'((int'(last_winner) + k) % N_REQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  // gating with Reset_n keeps gnt/rom_en low for the whole reset, even with req held
  assign grant = (state == IDLE) && Reset_n && found;
  always_comb begin
    state_nx = state;
    bus.gnt = '0;
    bus.rom_en = 1'b0;
    bus.rom_addr = '0;
    if (state == BURST) begin
      bus.rom_en = 1'b1;
      bus.rom_addr = base + ADDR_W'(row);
      state_nx = (row == 4'd15) ? IDLE : BURST;
    end else if (grant) begin
      bus.gnt[win] = 1'b1;
      bus.rom_en = 1'b1;
      bus.rom_addr = bus.req_addr[win*ADDR_W +: ADDR_W];
      state_nx = bus.req_burst[win] ? BURST : IDLE;
    end
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      last_winner <= IW'(N_REQ - 1);
      owner <= '0;
      row <= '0;
      base <= '0;
      rsp_valid_q <= '0;
      rsp_last_q <= 1'b0;
    end else begin
      state <= state_nx;
      rsp_valid_q <= '0;
      rsp_last_q <= 1'b0;
      if (state == BURST) begin
        row <= row + 4'd1;
        rsp_valid_q[owner] <= 1'b1;
        rsp_last_q <= (row == 4'd15);
      end else if (grant) begin
        last_winner <= win;
        owner <= win;
        base <= bus.req_addr[win*ADDR_W +: ADDR_W];
        row <= 4'(bus.req_burst[win]);
        rsp_valid_q[win] <= 1'b1;
        rsp_last_q <= !bus.req_burst[win];
      end
    end
  end
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_last = rsp_last_q;
  assign bus.rsp_data = DATA_W'(bus.rom_data);
endmodule

// File: tb/tb_font_rom_arbiter.sv
// tb_font_rom_arbiter: directed and random requests checked against a queue-based model of grants and responses.
module tb_font_rom_arbiter;
  localparam int N = 4, AW = 11, DW = 8;
  logic Clk = 1'b0, Reset_n = 1'b0;
  int n_checks = 0, n_fail = 0;
  typedef struct {
    int owner;
    logic [AW-1:0] addr;
    bit last;
  } iss_t;
  iss_t burst_q[$];
  iss_t prev;
  bit prev_v = 1'b0;
  int last_w = N - 1;
  font_rom_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus();
  font_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));
  always #5 Clk = ~Clk;
  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return DW'(a * 7 + (a >> 4)) ^ 8'h5A;
  endfunction
  always @(posedge Clk) if (bus.rom_en) bus.rom_data <= rom_fn(bus.rom_addr);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic raise(input int i, input bit b, input logic [AW-1:0] a);
    bus.req[i] = 1'b1;
    bus.req_burst[i] = b;
    bus.req_addr[i*AW +: AW] = a;
  endtask
  task automatic chk_reset();
    @(negedge Clk);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_rom_en", bus.rom_en, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_last", bus.rsp_last, 0);
    burst_q.delete();
    prev_v = 1'b0;
    last_w = N - 1;
  endtask
  // one clock: check responses to last cycle's issue, then predict this cycle's issue
  task automatic cycle(input bit hold);
    logic [N-1:0] eg;
    iss_t cur;
    bit cur_v;
    @(negedge Clk);
    chk("rsp_valid", bus.rsp_valid, prev_v ? (1 << prev.owner) : 0);
    chk("rsp_last", bus.rsp_last, prev_v ? prev.last : 1'b0);
    if (prev_v) chk("rsp_data", bus.rsp_data, rom_fn(prev.addr));
    cur_v = 1'b0;
    eg = '0;
    if (burst_q.size() > 0) begin
      cur = burst_q.pop_front();
      cur_v = 1'b1;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int i = (last_w + k) % N;
        if (!cur_v && bus.req[i]) begin
          cur_v = 1'b1;
          eg[i] = 1'b1;
          last_w = i;
          cur.owner = i;
          cur.addr = bus.req_addr[i*AW +: AW];
          cur.last = !bus.req_burst[i];
          if (bus.req_burst[i])
            for (int r = 1; r < 16; r++) burst_q.push_back('{i, AW'(cur.addr + r), r == 15});
        end
      end
    end
    chk("gnt", bus.gnt, eg);
    chk("rom_en", bus.rom_en, cur_v);
    chk("rom_addr", bus.rom_addr, cur_v ? cur.addr : '0);
    prev = cur;
    prev_v = cur_v;
    @(posedge Clk);
    #1;
    if (!hold) bus.req = bus.req & ~eg;
  endtask
  initial begin
    bus.req = '0;
    bus.req_burst = '0;
    bus.req_addr = '0;
    raise(1, 1'b0, 11'h055);
    @(negedge Clk);
    chk_reset();
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    bus.req = '0;
    for (int i = 0; i < N; i++) raise(i, 1'b0, AW'(16 * i + 3));
    repeat (5) cycle(1'b1);
    bus.req = '0;
    repeat (2) cycle(1'b0);
    raise(2, 1'b0, 11'h410);
    repeat (2) cycle(1'b0);
    raise(1, 1'b1, 11'h650);
    repeat (3) cycle(1'b0);
    raise(0, 1'b0, 11'h123);
    repeat (16) cycle(1'b0);
    raise(3, 1'b1, 11'h7F8);
    repeat (18) cycle(1'b0);
    raise(2, 1'b1, 11'h300);
    repeat (6) cycle(1'b0);
    Reset_n = 1'b0;
    bus.req = 4'b1010;
    chk_reset();
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    bus.req = '0;
    repeat (3) cycle(1'b0);
    for (int i = 0; i < N; i++) raise(i, 1'b0, AW'(100 + i));
    cycle(1'b0);
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i] && $urandom_range(3) == 0)
          raise(i, $urandom_range(2) == 0, AW'($urandom));
        else if (bus.req[i] && $urandom_range(31) == 0)
          bus.req[i] = 1'b0;
      end
      cycle(1'b0);
    end
    bus.req = '0;
    repeat (20) cycle(1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
